i2s_dac_tx: RTL and testbench

I2S_DAC_TX -- requirements
Module: i2s_dac_tx

---
 rtl/i2s_dac_tx_pkg.sv | 19 +
 rtl/i2s_tx_fifo.sv | 85 ++++++++
 rtl/i2s_dac_tx.sv | 198 +++++++++++++++++++
 tb/tb_i2s_dac_tx.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/i2s_dac_tx_pkg.sv
// ---------------------------------------------------------------------------
// i2s_dac_tx_pkg -- shared audio definitions for the I2S DAC transmitter.
//   I2S_SLOT_BITS : width of one I2S channel slot (shift register width)
//   slot_t        : one slot worth of serial data, MSB transmitted first
//   i2s_state_e   : word-framing FSM states (SYNC, LEFT, RIGHT)
// ---------------------------------------------------------------------------
package i2s_dac_tx_pkg;

    localparam int I2S_SLOT_BITS = 32;

    typedef logic [I2S_SLOT_BITS-1:0] slot_t;

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } i2s_state_e;

endpackage

// File: rtl/i2s_tx_fifo.sv
// ---------------------------------------------------------------------------
// i2s_tx_fifo -- small synchronous FIFO holding stereo pairs.
//   clk, reset : system clock, synchronous active-high reset (flushes FIFO)
//   i_push     : write i_data (ignored while full, even with a pop)
//   i_pop      : drop the head entry (ignored while empty)
//   o_data     : head entry (undefined while empty)
//   o_full     : registered full flag
//   o_empty    : registered empty flag
// DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module i2s_tx_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             r_full;
    logic             r_empty;

    logic             w_do_push;
    logic             w_do_pop;
    logic [AW:0]      w_count_next;

    // Qualify push/pop with the registered flags and compute the next fill level.
    always_comb begin
        w_do_push    = i_push && !r_full;
        w_do_pop     = i_pop && !r_empty;
        w_count_next = r_count;
        if (w_do_push && !w_do_pop) begin
            w_count_next = r_count + 1'b1;
        end else if (!w_do_push && w_do_pop) begin
            w_count_next = r_count - 1'b1;
        end else begin
            w_count_next = r_count;
        end
    end

    // Pointers, fill level and the registered full/empty flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_count_next;
            r_full  <= (w_count_next == FULL_CNT);
            r_empty <= (w_count_next == '0);
        end
    end

    // Storage array; data is only meaningful between push and pop, so no reset.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_full  = r_full;
    assign o_empty = r_empty;

endmodule

// File: rtl/i2s_dac_tx.sv
// ---------------------------------------------------------------------------
// i2s_dac_tx -- I2S transmitter towards a codec DAC; the codec is clock master.
//   clk, reset      : system clock (>= 4x bclk), synchronous active-high reset
//   aud_bclk        : codec bit clock, asynchronous to clk
//   aud_daclrck     : codec word clock (0 = left, 1 = right), asynchronous
//   aud_dacdat      : serial data, one-bit delayed I2S framing, MSB first
//   in_left/right   : stereo sample pair, two's complement, DATA_W bits
//   in_valid/ready  : pair handshake into a BUF_DEPTH-deep buffer
//   underrun        : one-cycle pulse when a frame starts with no pair buffered
//   underrun_count  : saturating underrun counter, present only when the
//                     I2S_TX_UNDERRUN_CNT_EN macro is defined
// ---------------------------------------------------------------------------
module i2s_dac_tx
    import i2s_dac_tx_pkg::*;
#(
    parameter int DATA_W    = 24,
    parameter int BUF_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              aud_bclk,
    input  logic              aud_daclrck,
    output logic              aud_dacdat,
    input  logic [DATA_W-1:0] in_left,
    input  logic [DATA_W-1:0] in_right,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              underrun
`ifdef I2S_TX_UNDERRUN_CNT_EN
    ,
    output logic [15:0]       underrun_count
`endif
);

    localparam int          PAD_BITS = I2S_SLOT_BITS - DATA_W;
    localparam logic [5:0]  LAST_BIT = 6'(DATA_W);

    // Pin synchronizers: two flops each, third stage only for edge detection.
    logic r_bclk_meta, r_bclk_sync, r_bclk_dly;
    logic r_lrck_meta, r_lrck_sync, r_lrck_dly;
    logic w_bclk_fall, w_lrck_fall, w_lrck_rise;

    i2s_state_e r_state, w_state_next;
    logic       w_load_left, w_load_right, w_pop, w_underrun;

    logic                  w_push, w_fifo_full, w_fifo_empty;
    logic [2*DATA_W-1:0]   w_fifo_data;
    logic [DATA_W-1:0]     w_left_sample, w_right_sample;

    slot_t             r_shift;
    logic [DATA_W-1:0] r_right_latch;
    logic [5:0]        r_bit_cnt;
    logic              r_dacdat;
    logic              r_underrun;

    // Bring the codec clocks into the clk domain.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bclk_meta <= 1'b0;
            r_bclk_sync <= 1'b0;
            r_bclk_dly  <= 1'b0;
            r_lrck_meta <= 1'b0;
            r_lrck_sync <= 1'b0;
            r_lrck_dly  <= 1'b0;
        end else begin
            r_bclk_meta <= aud_bclk;
            r_bclk_sync <= r_bclk_meta;
            r_bclk_dly  <= r_bclk_sync;
            r_lrck_meta <= aud_daclrck;
            r_lrck_sync <= r_lrck_meta;
            r_lrck_dly  <= r_lrck_sync;
        end
    end

    assign w_bclk_fall = r_bclk_dly & ~r_bclk_sync;
    assign w_lrck_fall = r_lrck_dly & ~r_lrck_sync;
    assign w_lrck_rise = ~r_lrck_dly & r_lrck_sync;

    // Pair buffer; left sample occupies the upper half of each entry.
    assign in_ready = !w_fifo_full;
    assign w_push   = in_valid && in_ready;

    i2s_tx_fifo #(
        .WIDTH (2 * DATA_W),
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  ({in_left, in_right}),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // An empty buffer at frame start plays silence on both channels.
    assign w_left_sample  = w_fifo_empty ? {DATA_W{1'b0}} : w_fifo_data[2*DATA_W-1:DATA_W];
    assign w_right_sample = w_fifo_empty ? {DATA_W{1'b0}} : w_fifo_data[DATA_W-1:0];

    // Framing FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= SYNC;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Framing FSM next state: a frame starts on every word-clock falling edge.
    always_comb begin
        w_state_next = r_state;
        w_load_left  = 1'b0;
        w_load_right = 1'b0;
        w_pop        = 1'b0;
        w_underrun   = 1'b0;
        case (r_state)
            SYNC, RIGHT: begin
                if (w_lrck_fall) begin
                    w_state_next = LEFT;
                    w_load_left  = 1'b1;
                    w_pop        = !w_fifo_empty;
                    w_underrun   = w_fifo_empty;
                end else begin
                    w_state_next = r_state;
                end
            end
            LEFT: begin
                if (w_lrck_rise) begin
                    w_state_next = RIGHT;
                    w_load_right = 1'b1;
                end else begin
                    w_state_next = LEFT;
                end
            end
            default: begin
                w_state_next = SYNC;
            end
        endcase
    end

    // Serializer. r_bit_cnt: 0 = delay bit still owed, 1..DATA_W = next data
    // bit, beyond that the slot is padded with zeros until the next word edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift       <= '0;
            r_right_latch <= '0;
            r_bit_cnt     <= 6'd0;
            r_dacdat      <= 1'b0;
            r_underrun    <= 1'b0;
        end else begin
            r_underrun <= w_underrun;
            if (w_load_left || w_load_right) begin
                if (w_load_left) begin
                    r_shift       <= slot_t'(w_left_sample) << PAD_BITS;
                    r_right_latch <= w_right_sample;
                end else begin
                    r_shift <= slot_t'(r_right_latch) << PAD_BITS;
                end
                // The bclk edge that coincides with the word edge is the delay bit.
                r_bit_cnt <= w_bclk_fall ? 6'd1 : 6'd0;
                r_dacdat  <= 1'b0;
            end else if (r_state == SYNC) begin
                r_dacdat <= 1'b0;
            end else if (w_bclk_fall) begin
                if (r_bit_cnt == 6'd0) begin
                    r_dacdat  <= 1'b0;
                    r_bit_cnt <= 6'd1;
                end else if (r_bit_cnt <= LAST_BIT) begin
                    r_dacdat  <= r_shift[I2S_SLOT_BITS-1];
                    r_shift   <= r_shift << 1;
                    r_bit_cnt <= r_bit_cnt + 6'd1;
                end else begin
                    r_dacdat <= 1'b0;
                end
            end
        end
    end

    assign aud_dacdat = r_dacdat;
    assign underrun   = r_underrun;

`ifdef I2S_TX_UNDERRUN_CNT_EN
    logic [15:0] r_underrun_cnt;

    // Saturating count of underrun pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_underrun_cnt <= 16'd0;
        end else if (r_underrun && (r_underrun_cnt != 16'hFFFF)) begin
            r_underrun_cnt <= r_underrun_cnt + 16'd1;
        end
    end

    assign underrun_count = r_underrun_cnt;
`endif

endmodule

// File: tb/tb_i2s_dac_tx.sv
// ---------------------------------------------------------------------------
// tb_i2s_dac_tx -- drives two transmitters (DATA_W = 24 and DATA_W = 16) from
// one emulated codec (bclk = 8 clk periods, 64 bclk per frame) and compares
// every captured slot with the I2S framing rules computed from plain
// arithmetic on the samples held in a queue-based buffer model.
// ---------------------------------------------------------------------------
module tb_i2s_dac_tx;

    logic        clk = 1'b0;
    logic        reset;
    logic        bclk;
    logic        lrck;

    logic [23:0] l24, r24;
    logic        v24;
    logic        dat24, rdy24, und24;
    logic [15:0] l16, r16;
    logic        v16;
    logic        dat16, rdy16, und16;
`ifdef I2S_TX_UNDERRUN_CNT_EN
    logic [15:0] ucnt24, ucnt16;
`endif

    int vectors     = 0;
    int miscompares = 0;
    int und_seen24  = 0;
    int und_seen16  = 0;
    int exp_und24   = 0;
    int exp_und16   = 0;
    int exp_hw24    = 0;
    int exp_hw16    = 0;

    logic [47:0] q24[$];
    logic [31:0] q16[$];

    always #5 clk = ~clk;

    i2s_dac_tx #(.DATA_W(24), .BUF_DEPTH(2)) dut24 (
        .clk(clk), .reset(reset), .aud_bclk(bclk), .aud_daclrck(lrck),
        .aud_dacdat(dat24), .in_left(l24), .in_right(r24), .in_valid(v24),
        .in_ready(rdy24), .underrun(und24)
`ifdef I2S_TX_UNDERRUN_CNT_EN
        , .underrun_count(ucnt24)
`endif
    );

    i2s_dac_tx #(.DATA_W(16), .BUF_DEPTH(2)) dut16 (
        .clk(clk), .reset(reset), .aud_bclk(bclk), .aud_daclrck(lrck),
        .aud_dacdat(dat16), .in_left(l16), .in_right(r16), .in_valid(v16),
        .in_ready(rdy16), .underrun(und16)
`ifdef I2S_TX_UNDERRUN_CNT_EN
        , .underrun_count(ucnt16)
`endif
    );

    // Count clk cycles with underrun high (also catches over-long pulses).
    always @(posedge clk) begin
        if (und24 === 1'b1) und_seen24 <= und_seen24 + 1;
        if (und16 === 1'b1) und_seen16 <= und_seen16 + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected slot: bit k is the value in bclk period k after the word edge.
    function automatic logic [31:0] slot_bits(input logic [31:0] sample, input int dw);
        logic [31:0] v;
        v = 32'd0;
        for (int k = 1; k <= dw; k++) v[k] = sample[dw - k];
        return v;
    endfunction

    function automatic int sat_inc(input int x);
        return (x < 65535) ? x + 1 : x;
    endfunction

    task automatic push_pair(input logic [23:0] a24, input logic [23:0] b24,
                             input logic [15:0] a16, input logic [15:0] b16);
        bit e24, e16;
        e24 = (q24.size() < 2);
        e16 = (q16.size() < 2);
        @(negedge clk);
        check("in_ready24", 64'(rdy24), 64'(e24));
        check("in_ready16", 64'(rdy16), 64'(e16));
        l24 = a24; r24 = b24; v24 = 1'b1;
        l16 = a16; r16 = b16; v16 = 1'b1;
        @(negedge clk);
        v24 = 1'b0; v16 = 1'b0;
        if (e24) q24.push_back({a24, b24});
        if (e16) q16.push_back({a16, b16});
    endtask

    // One full stereo frame; optional in_ready timing check after the
    // falling word edge and optional reset pulse after sampling slot rst_slot.
    task automatic run_frame(input bit chk_ready, input int rst_slot);
        logic [47:0] p24;
        logic [31:0] p16;
        logic [63:0] cap24, cap16, exp24, exp16, mask;
        bit rd24, rd16;
        if (q24.size() > 0) p24 = q24.pop_front();
        else begin p24 = 48'd0; exp_und24++; exp_hw24 = sat_inc(exp_hw24); end
        if (q16.size() > 0) p16 = q16.pop_front();
        else begin p16 = 32'd0; exp_und16++; exp_hw16 = sat_inc(exp_hw16); end
        cap24 = 64'd0; cap16 = 64'd0; mask = ~64'd0;
        rd24 = 1'b0; rd16 = 1'b0;
        for (int s = 0; s < 64; s++) begin
            @(negedge clk);
            bclk = 1'b0;
            lrck = (s >= 32);
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                if (rdy24) rd24 = 1'b1;
                if (rdy16) rd16 = 1'b1;
            end
            if (chk_ready && s == 0) begin
                check("ready_after_pop24", 64'(rd24), 64'd1);
                check("ready_after_pop16", 64'(rd16), 64'd1);
            end
            bclk = 1'b1;
            repeat (3) @(negedge clk);
            cap24[s] = dat24;
            cap16[s] = dat16;
            if (s == rst_slot) begin
                reset = 1'b1;
                @(posedge clk);
                #1;
                check("rst_dacdat24", 64'(dat24), 64'd0);
                check("rst_dacdat16", 64'(dat16), 64'd0);
                check("rst_ready24", 64'(rdy24), 64'd1);
                check("rst_underrun24", 64'(und24), 64'd0);
                @(negedge clk);
                reset = 1'b0;
                q24.delete();
                q16.delete();
                exp_hw24 = 0;
                exp_hw16 = 0;
                mask = (64'd1 << (s + 1)) - 64'd1;
            end
        end
        exp24 = {slot_bits(32'(p24[23:0]), 24), slot_bits(32'(p24[47:24]), 24)} & mask;
        exp16 = {slot_bits(32'(p16[15:0]), 16), slot_bits(32'(p16[31:16]), 16)} & mask;
        check("left24", 64'(cap24[31:0]), 64'(exp24[31:0]));
        check("right24", 64'(cap24[63:32]), 64'(exp24[63:32]));
        check("left16", 64'(cap16[31:0]), 64'(exp16[31:0]));
        check("right16", 64'(cap16[63:32]), 64'(exp16[63:32]));
        check("underrun_cycles24", 64'(und_seen24), 64'(exp_und24));
        check("underrun_cycles16", 64'(und_seen16), 64'(exp_und16));
`ifdef I2S_TX_UNDERRUN_CNT_EN
        check("underrun_count24", 64'(ucnt24), 64'(exp_hw24));
        check("underrun_count16", 64'(ucnt16), 64'(exp_hw16));
`endif
    endtask

    initial begin
        reset = 1'b1; bclk = 1'b1; lrck = 1'b0;
        l24 = 24'd0; r24 = 24'd0; v24 = 1'b0;
        l16 = 16'd0; r16 = 16'd0; v16 = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_dacdat24", 64'(dat24), 64'd0);
        check("reset_dacdat16", 64'(dat16), 64'd0);
        check("reset_ready24", 64'(rdy24), 64'd1);
        check("reset_ready16", 64'(rdy16), 64'd1);
        check("reset_underrun24", 64'(und24), 64'd0);
        check("reset_underrun16", 64'(und16), 64'd0);

        // Word clock already low out of reset: no frame may start.
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check("no_false_fall24", 64'(und_seen24), 64'd0);
        check("no_false_fall16", 64'(und_seen16), 64'd0);
        lrck = 1'b1;
        repeat (10) @(negedge clk);
        check("sync_dacdat24", 64'(dat24), 64'd0);

        // Three frames with nothing buffered: silence and one underrun each.
        repeat (3) run_frame(1'b0, -1);

        // Fill the buffer, refuse a third pair, drain it frame by frame.
        push_pair(24'h800001, 24'h7FFFFF, 16'hA5A5, 16'hA5A5);
        push_pair(24'($urandom), 24'($urandom), 16'($urandom), 16'($urandom));
        push_pair(24'($urandom), 24'($urandom), 16'($urandom), 16'($urandom));
        run_frame(1'b1, -1);
        run_frame(1'b0, -1);
        run_frame(1'b0, -1);

        // Random fill levels between frames.
        for (int i = 0; i < 4; i++) begin
            int n;
            n = $urandom_range(0, 3);
            for (int j = 0; j < n; j++)
                push_pair(24'($urandom), 24'($urandom), 16'($urandom), 16'($urandom));
            run_frame(1'b0, -1);
        end

        // Reset in the middle of a left word that is driving a 1.
        push_pair(24'hFFF0F0, 24'($urandom), 16'hF0F0, 16'($urandom));
        push_pair(24'($urandom), 24'($urandom), 16'($urandom), 16'($urandom));
        run_frame(1'b0, 10);
        push_pair(24'($urandom), 24'($urandom), 16'($urandom), 16'($urandom));
        run_frame(1'b0, -1);

`ifdef I2S_TX_UNDERRUN_CNT_EN
        force dut24.r_underrun_cnt = 16'hFFFF;
        @(negedge clk);
        release dut24.r_underrun_cnt;
        exp_hw24 = 65535;
        run_frame(1'b0, -1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
